// File: rtl/vga_fb_scheduler.sv
// Shares one single-port framebuffer RAM between scan-out fetches (always win) and a pixel writer.
// Fetch lands 2-3 cycles after its pix_tick; write ack 1 cycle after request, at most 3 when behind a fetch.
module vga_fb_scheduler #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int H_START     = 144,
  parameter int V_START     = 35,
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              pix_tick,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              vid_on,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data
);

  localparam logic [9:0]      H_LO     = 10'(H_START - 2);
  localparam logic [9:0]      H_HI     = 10'(H_START + H_ACT - 6);
  localparam logic [9:0]      V_LO     = 10'(V_START);
  localparam logic [9:0]      V_HI     = 10'(V_START + V_ACT - 1);
  localparam logic [ADDR_W:0] FB_CELLS = (ADDR_W + 1)'(FB_W * FB_H);

  typedef enum logic [1:0] {IDLE, VID_RD, VID_CAP, WR} state_t;

  state_t            state;
  logic              vid_pend;
  logic              load_pend;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] pix_buf;
  logic [DATA_W-1:0] pix_reg;

  logic [9:0]        h_off;
  logic [9:0]        v_off;
  logic [9:0]        cell_row;
  logic [9:0]        cell_col;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] fetch_addr_nxt;
  logic              fetch_due;
  logic              wr_in_range;

  // Fetch two pixels ahead of the cell's first displayed column so data is ready on time.
  assign h_off    = h_cnt - H_LO;
  assign v_off    = v_cnt - V_LO;
  assign cell_row = v_off >> SCALE_SHIFT;
  assign cell_col = h_off >> SCALE_SHIFT;
  assign row_base = ADDR_W'(cell_row);
  assign fetch_addr_nxt = (row_base << 7) + (row_base << 5) + ADDR_W'(cell_col);

  assign fetch_due = pix_tick
                   && (v_cnt >= V_LO) && (v_cnt <= V_HI)
                   && (h_cnt >= H_LO) && (h_cnt <= H_HI)
                   && (h_off[SCALE_SHIFT-1:0] == '0);

  assign wr_in_range = ({1'b0, wr_addr} < FB_CELLS);

  assign pix_data = vid_on ? pix_reg : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      vid_pend   <= 1'b0;
      load_pend  <= 1'b0;
      fetch_addr <= '0;
      pix_buf    <= '0;
      pix_reg    <= '0;
      wr_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      wr_ack <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;

      if (pix_tick && load_pend) begin
        pix_reg   <= pix_buf;
        load_pend <= 1'b0;
      end

      if (fetch_due) begin
        fetch_addr <= fetch_addr_nxt;
        vid_pend   <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (vid_pend) begin
            state    <= VID_RD;
            mem_en   <= 1'b1;
            mem_addr <= fetch_addr;
          end else if (wr_req) begin
            state     <= WR;
            wr_ack    <= 1'b1;
            mem_en    <= wr_in_range;
            mem_we    <= wr_in_range;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
          end
        end
        VID_RD: begin
          if (!fetch_due) vid_pend <= 1'b0;
          state <= VID_CAP;
        end
        VID_CAP: begin
          pix_buf   <= mem_rdata;
          load_pend <= 1'b1;
          if (wr_req) begin
            state     <= WR;
            wr_ack    <= 1'b1;
            mem_en    <= wr_in_range;
            mem_we    <= wr_in_range;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
          end else begin
            state <= IDLE;
          end
        end
        WR: begin
          // wr_req here is still the request being acknowledged; a new one is seen from IDLE.
          if (vid_pend) begin
            state    <= VID_RD;
            mem_en   <= 1'b1;
            mem_addr <= fetch_addr;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
